// File: rtl/sr_flag_bank.sv
// Bank of NCH set/reset status flags with sticky overrun, write-1-to-clear and interrupt masking.
// Feeds the UART status read mux and drives the single UART interrupt line.
module sr_flag_bank #(
    parameter int unsigned    NCH          = 8,
    parameter bit             SET_PRIORITY = 1'b1,
    parameter logic [NCH-1:0] EDGE_MODE    = '0,
    parameter logic [NCH-1:0] RST_FLAGS    = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] set,
    input  logic [NCH-1:0] clr,
    input  logic           w1c_we,
    input  logic [NCH-1:0] w1c_data,
    input  logic           mask_we,
    input  logic [NCH-1:0] mask_data,
    output logic [NCH-1:0] flags,
    output logic [NCH-1:0] ovr,
    output logic [NCH-1:0] mask,
    output logic           irq
);

    logic [NCH-1:0] flags_q, flags_d;
    logic [NCH-1:0] ovr_q, ovr_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] set_prev_q;
    logic [NCH-1:0] set_eff;
    logic [NCH-1:0] clr_eff;
    logic [NCH-1:0] w1c_bits;

    always_comb begin
        w1c_bits = w1c_we ? w1c_data : '0;
        // Edge channels only fire on a low-to-high transition of their set input.
        set_eff  = (EDGE_MODE & set & ~set_prev_q) | (~EDGE_MODE & set);
        clr_eff  = clr | w1c_bits;

        if (SET_PRIORITY) begin
            flags_d = set_eff | (flags_q & ~clr_eff);
        end else begin
            flags_d = (set_eff | flags_q) & ~clr_eff;
        end

        // A fresh overrun wins over a same-cycle W1C; hardware clr leaves ovr alone.
        ovr_d  = (ovr_q & ~w1c_bits) | (set_eff & flags_q);
        mask_d = mask_we ? mask_data : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= RST_FLAGS;
            ovr_q      <= '0;
            mask_q     <= '1;
            set_prev_q <= '1;
        end else begin
            flags_q    <= flags_d;
            ovr_q      <= ovr_d;
            mask_q     <= mask_d;
            set_prev_q <= set;
        end
    end

    assign flags = flags_q;
    assign ovr   = ovr_q;
    assign mask  = mask_q;
    assign irq   = |(flags_q & ~mask_q);

endmodule
